// File: rtl/ibex_xif_rvfi_retire_sched.sv
// ibex_xif_rvfi_retire_sched: merges core and XIF retirement records into one in-order RVFI stream.
// Optional stall watchdog is enabled by defining RVFI_RETIRE_SCHED_WATCHDOG_EN.
module ibex_xif_rvfi_retire_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ORDER_W   = 64,
  parameter int unsigned PAYLOAD_W = 256,
  parameter int unsigned STALL_MAX = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_valid_i,
  input  logic [ORDER_W-1:0]     core_order_i,
  input  logic [PAYLOAD_W-1:0]   core_payload_i,
  output logic                   core_ready_o,
  input  logic                   xif_valid_i,
  input  logic [ORDER_W-1:0]     xif_order_i,
  input  logic [PAYLOAD_W-1:0]   xif_payload_i,
  output logic                   xif_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ORDER_W-1:0]     out_order_o,
  output logic [PAYLOAD_W-1:0]   out_payload_o,
  output logic                   out_src_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic                   dup_err_o,
  output logic                   stall_err_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STALL_MAX == 0) begin : g_param_check
    $error("DEPTH must be a power of two >= 2 and STALL_MAX nonzero");
  end

  logic [ORDER_W-1:0]   head_q, core_dist, xif_dist;
  logic [DEPTH-1:0]     vld_q, vld_d, src_q;
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [CNT_W-1:0]     cnt_q;
  logic                 dup_q;
  logic [IDX_W-1:0]     head_idx, core_idx, xif_idx;
  logic                 core_win, xif_win, core_fire, xif_fire, drain;

  assign head_idx  = head_q[IDX_W-1:0];
  assign core_idx  = core_order_i[IDX_W-1:0];
  assign xif_idx   = xif_order_i[IDX_W-1:0];
  assign core_dist = core_order_i - head_q;
  assign xif_dist  = xif_order_i - head_q;
  assign core_win  = core_dist < ORDER_W'(DEPTH);
  assign xif_win   = xif_dist < ORDER_W'(DEPTH);

  assign core_ready_o = core_win && !vld_q[core_idx];
  // Both producers targeting the same empty slot: the core wins, XIF is refused.
  assign xif_ready_o  = xif_win && !vld_q[xif_idx] && !(core_fire && core_idx == xif_idx);
  assign core_fire    = core_valid_i && core_ready_o;
  assign xif_fire     = xif_valid_i && xif_ready_o;

  // The valid head slot always holds order head_q, so the order is not stored.
  assign out_valid_o   = vld_q[head_idx];
  assign drain         = out_valid_o && out_ready_i;
  assign out_order_o   = out_valid_o ? head_q : '0;
  assign out_payload_o = out_valid_o ? pay_q[head_idx] : '0;
  assign out_src_o     = out_valid_o && src_q[head_idx];
  assign occupancy_o   = cnt_q;
  assign dup_err_o     = dup_q;

  always_comb begin
    vld_d           = vld_q;
    vld_d[head_idx] = vld_q[head_idx] && !drain;
    vld_d[core_idx] = vld_d[core_idx] || core_fire;
    vld_d[xif_idx]  = vld_d[xif_idx] || xif_fire;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
      dup_q  <= 1'b0;
    end else begin
      head_q <= head_q + ORDER_W'(drain);
      vld_q  <= vld_d;
      cnt_q  <= cnt_q + CNT_W'(core_fire) + CNT_W'(xif_fire) - CNT_W'(drain);
      dup_q  <= (core_valid_i && core_win && !core_ready_o) || (xif_valid_i && xif_win && !xif_ready_o);
    end
  end

  always_ff @(posedge clk_i) begin
    if (core_fire) begin
      pay_q[core_idx] <= core_payload_i;
      src_q[core_idx] <= 1'b0;
    end
    if (xif_fire) begin
      pay_q[xif_idx] <= xif_payload_i;
      src_q[xif_idx] <= 1'b1;
    end
  end

`ifdef RVFI_RETIRE_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(STALL_MAX + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            stall_q;

  // Counts cycles with buffered records but a missing head; saturates at STALL_MAX.
  assign wd_d = (drain || cnt_q == '0) ? '0 :
                (out_valid_o || wd_q == WD_W'(STALL_MAX)) ? wd_q : wd_q + 1'b1;
  assign stall_err_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stall_q <= stall_q || wd_d == WD_W'(STALL_MAX);
    end
  end
`else
  assign stall_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_xif_rvfi_retire_sched.sv
// tb_ibex_xif_rvfi_retire_sched: directed + randomized stimulus, scoreboard monitor keyed by order number.
module tb_ibex_xif_rvfi_retire_sched;
  localparam int DEPTH = 8;
  localparam int OW    = 8;
  localparam int PW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_valid, xif_valid, out_ready;
  logic [OW-1:0] core_order, xif_order, out_order;
  logic [PW-1:0] core_payload, xif_payload, out_payload;
  logic          core_ready, xif_ready, out_valid, out_src, dup_err, stall_err;
  logic [3:0]    occupancy;

  int checks = 0;
  int failures = 0;
  int drained = 0;
  int dups = 0;

  always #5 clk = ~clk;

  ibex_xif_rvfi_retire_sched #(
    .DEPTH(DEPTH), .ORDER_W(OW), .PAYLOAD_W(PW), .STALL_MAX(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_valid_i(core_valid), .core_order_i(core_order), .core_payload_i(core_payload), .core_ready_o(core_ready),
    .xif_valid_i(xif_valid), .xif_order_i(xif_order), .xif_payload_i(xif_payload), .xif_ready_o(xif_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_order_o(out_order), .out_payload_o(out_payload),
    .out_src_o(out_src), .occupancy_o(occupancy), .dup_err_o(dup_err), .stall_err_o(stall_err)
  );

  // Reference model: records held, keyed by order; nxt is the next order owed to the consumer.
  typedef struct packed {
    logic [PW-1:0] p;
    logic          s;
  } rec_t;

  rec_t          held [logic [OW-1:0]];
  logic [OW-1:0] nxt;
  bit            dup_exp;
  logic [OW-1:0] cq[$], xq[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit in_win(input logic [OW-1:0] o);
    logic [OW-1:0] d = o - nxt;
    return int'(d) < DEPTH;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held.delete();
      nxt = '0;
      dup_exp = 1'b0;
    end else begin
      bit cr, xr, ov;
      cr = in_win(core_order) && !held.exists(core_order);
      xr = in_win(xif_order) && !held.exists(xif_order) && !(core_valid && cr && core_order == xif_order);
      ov = held.exists(nxt);
      dups += int'(dup_err);
      chk("core_ready", 64'(core_ready), 64'(cr));
      chk("xif_ready", 64'(xif_ready), 64'(xr));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("occupancy", 64'(occupancy), 64'(held.num()));
      chk("dup_err", 64'(dup_err), 64'(dup_exp));
`ifndef RVFI_RETIRE_SCHED_WATCHDOG_EN
      chk("stall_err", 64'(stall_err), 64'd0);
`endif
      if (ov) begin
        chk("out_order", 64'(out_order), 64'(nxt));
        chk("out_payload", 64'(out_payload), 64'(held[nxt].p));
        chk("out_src", 64'(out_src), 64'(held[nxt].s));
      end
      dup_exp = (core_valid && in_win(core_order) && !cr) || (xif_valid && in_win(xif_order) && !xr);
      if (core_valid && cr) held[core_order] = '{p: core_payload, s: 1'b0};
      if (xif_valid && xr) held[xif_order] = '{p: xif_payload, s: 1'b1};
      if (ov && out_ready) begin
        held.delete(nxt);
        nxt = nxt + 1'b1;
        drained++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called and returns at posedge+1; holds valid until the producer sees ready.
  task automatic send(input bit s, input logic [OW-1:0] o, input logic [PW-1:0] p);
    bit rdy = 1'b0;
    if (s) begin
      xif_valid = 1'b1; xif_order = o; xif_payload = p;
    end else begin
      core_valid = 1'b1; core_order = o; core_payload = p;
    end
    for (int i = 0; i < 2000 && !rdy; i++) begin
      @(negedge clk);
      rdy = s ? xif_ready : core_ready;
    end
    @(posedge clk);
    #1;
    if (s) xif_valid = 1'b0;
    else core_valid = 1'b0;
    chk("send_accept", 64'(rdy), 64'd1);
  endtask

  task automatic wait_head(input logic [OW-1:0] t);
    for (int i = 0; i < 4000 && nxt != t; i++) idle(1);
    chk("head_reach", 64'(nxt), 64'(t));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    core_valid = 1'b0; xif_valid = 1'b0; out_ready = 1'b0;
    core_order = '0; xif_order = '0; core_payload = '0; xif_payload = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_dup_err", 64'(dup_err), 64'd0);
    chk("rst_stall_err", 64'(stall_err), 64'd0);
    chk("rst_out_order", 64'(out_order), 64'd0);
    chk("rst_out_payload", 64'(out_payload), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // In-order core stream
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b0, 8'(i), $urandom);
    wait_head(8'd3);

    // XIF record ahead of its predecessor
    fork
      send(1'b1, 8'd4, $urandom);
      begin idle(2); send(1'b0, 8'd3, $urandom); end
    join
    wait_head(8'd5);

    // Fill the window behind a missing head, then release it
    out_ready = 1'b0;
    for (int o = 6; o <= 12; o++) send(1'b0, 8'(o), $urandom);
    send(1'b1, 8'd5, $urandom);
    chk("occupancy_full", 64'(occupancy), 64'd8);
    fork
      send(1'b0, 8'd13, $urandom);
      out_ready = 1'b1;
    join
    wait_head(8'd14);

    // Same-cycle collision, then an XIF retry into the occupied slot
    out_ready = 1'b0;
    core_valid = 1'b1; core_order = 8'd17; core_payload = $urandom;
    xif_valid = 1'b1; xif_order = 8'd17; xif_payload = $urandom;
    idle(1);
    core_valid = 1'b0;
    idle(1);
    xif_valid = 1'b0;
    idle(1);
    chk("dup_pulses", 64'(dups), 64'd2);
    out_ready = 1'b1;
    fork
      send(1'b0, 8'd14, $urandom);
      begin send(1'b1, 8'd15, $urandom); send(1'b1, 8'd16, $urandom); end
    join
    wait_head(8'd18);

    // Random merge across the order wrap with random backpressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) xq.push_back(8'(18 + i));
      else cq.push_back(8'(18 + i));
    end
    fork
      foreach (cq[i]) begin idle(int'($urandom_range(0, 2))); send(1'b0, cq[i], $urandom); end
      foreach (xq[i]) begin idle(int'($urandom_range(0, 2))); send(1'b1, xq[i], $urandom); end
      begin
        for (int k = 0; k < 5000 && drained < 318; k++) begin
          out_ready = $urandom_range(0, 3) != 0;
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    chk("drained_total", 64'(drained), 64'd318);
    chk("dup_pulses_final", 64'(dups), 64'd2);

    // Reset while records are buffered
    out_ready = 1'b0;
    send(1'b0, 8'd63, $urandom);
    send(1'b1, 8'd64, $urandom);
    chk("occ_before_reset", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("occ_async_reset", 64'(occupancy), 64'd0);
    chk("out_valid_async_reset", 64'(out_valid), 64'd0);
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b1, 8'd0, $urandom);
    wait_head(8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
